// File: rtl/i2c_reg_ctrl.sv
// Register-level I2C master sequencer: turns a single-byte register write/read
// request into the ordered Cmd/Go/Tx_DATA steps executed by i2c_bit_shifter.
module i2c_reg_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       wrreg_req,
    input  logic       rdreg_req,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    output logic [7:0] rddata,
    output logic       RW_Done,
    output logic       err,
    output logic       busy,
    output logic [5:0] Cmd,
    output logic       Go,
    output logic [7:0] Tx_DATA,
    input  logic [7:0] Rx_DATA,
    input  logic       Trans_Done,
    input  logic       ack_o
);

    localparam logic [5:0] CMD_WR   = 6'h01;
    localparam logic [5:0] CMD_STA  = 6'h02;
    localparam logic [5:0] CMD_RD   = 6'h04;
    localparam logic [5:0] CMD_STO  = 6'h08;
    localparam logic [5:0] CMD_NACK = 6'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_step;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_is_rd;
    logic       r_abort;
    logic       r_go;
    logic [5:0] r_cmd;
    logic [7:0] r_tx;
    logic [7:0] r_rddata;
    logic       r_err;

    logic [5:0] w_step_cmd;
    logic [7:0] w_step_tx;
    logic       w_last;
    logic       w_accept;
    logic       w_nack;
    logic       w_capture;
    logic       w_advance;

    // Command/byte for the step currently being issued or awaited
    always_comb begin
        w_step_cmd = '0;
        w_step_tx  = '0;
        case ({r_is_rd, r_step})
            3'b000, 3'b100: begin
                w_step_cmd = CMD_STA | CMD_WR;
                w_step_tx  = {DEV_ADDR, 1'b0};
            end
            3'b001, 3'b101: begin
                w_step_cmd = CMD_WR;
                w_step_tx  = r_addr;
            end
            3'b010: begin
                w_step_cmd = CMD_WR | CMD_STO;
                w_step_tx  = r_wdata;
            end
            3'b110: begin
                w_step_cmd = CMD_STA | CMD_WR;
                w_step_tx  = {DEV_ADDR, 1'b1};
            end
            3'b111: begin
                w_step_cmd = CMD_RD | CMD_NACK | CMD_STO;
                w_step_tx  = '0;
            end
            default: begin
                w_step_cmd = '0;
                w_step_tx  = '0;
            end
        endcase
    end

    assign w_last = r_is_rd ? (r_step == 2'd3) : (r_step == 2'd2);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_nack    = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wrreg_req || rdreg_req) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_ABORT: w_next = S_WAIT;
            S_WAIT: begin
                if (Trans_Done) begin
                    if (r_abort) begin
                        w_next = S_DONE;
                    end else if (w_step_cmd[0] && ack_o) begin
                        // A NACK on a step that already carries STO ends the bus cleanly
                        w_nack = 1'b1;
                        w_next = w_step_cmd[3] ? S_DONE : S_ABORT;
                    end else if (w_last) begin
                        w_capture = r_is_rd;
                        w_next    = S_DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = S_ISSUE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_is_rd  <= 1'b0;
            r_abort  <= 1'b0;
            r_go     <= 1'b0;
            r_cmd    <= '0;
            r_tx     <= '0;
            r_rddata <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_go    <= (r_state == S_ISSUE) || (r_state == S_ABORT);
            if (r_state == S_ISSUE) begin
                r_cmd <= w_step_cmd;
                r_tx  <= w_step_tx;
            end
            if (r_state == S_ABORT) begin
                r_cmd   <= CMD_STO;
                r_tx    <= '0;
                r_abort <= 1'b1;
            end
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wrdata;
                r_is_rd <= !wrreg_req;
                r_err   <= 1'b0;
                r_step  <= '0;
                r_abort <= 1'b0;
            end
            if (w_nack) begin
                r_err <= 1'b1;
            end
            if (w_capture) begin
                r_rddata <= Rx_DATA;
            end
            if (w_advance) begin
                r_step <= r_step + 2'd1;
            end
        end
    end

    assign rddata  = r_rddata;
    assign RW_Done = (r_state == S_DONE);
    assign err     = r_err;
    assign busy    = (r_state != S_IDLE);
    assign Cmd     = r_cmd;
    assign Go      = r_go;
    assign Tx_DATA = r_tx;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: the bench plays the bit shifter and
// compares every Go strobe and completion against a step-list reference model.
module tb_i2c_reg_ctrl;

    localparam logic [7:0] DEV_W = 8'hA0;
    localparam logic [7:0] DEV_R = 8'hA1;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       wrreg_req, rdreg_req;
    logic [7:0] addr, wrdata;
    logic [7:0] rddata;
    logic       RW_Done, err, busy;
    logic [5:0] Cmd;
    logic       Go;
    logic [7:0] Tx_DATA;
    logic [7:0] Rx_DATA;
    logic       Trans_Done, ack_o;

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    logic [7:0] m_rddata = 8'h00;

    i2c_reg_ctrl #(.DEV_ADDR(7'h50)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
        .addr(addr), .wrdata(wrdata), .rddata(rddata), .RW_Done(RW_Done),
        .err(err), .busy(busy), .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA),
        .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done), .ack_o(ack_o)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_go(output int wt);
        wt = 0;
        while (Go !== 1'b1 && wt < 20) begin
            @(negedge Clk);
            Trans_Done = 1'b0;
            wt++;
        end
    endtask

    // One request; nack_step = -1 for a clean run. The expected Go list is built from the step rules.
    task automatic run_req(input bit wr, input bit both, input logic [7:0] a, input logic [7:0] d,
                           input int nack_step, input logic [7:0] rx);
        logic [5:0] ecmd[5];
        logic [7:0] etx[5];
        int         len, n, wt;
        bit         rd_op, fault;
        logic [7:0] exp_rd;

        rd_op = !wr && !both;
        if (!rd_op) begin
            ecmd[0] = 6'h03; etx[0] = DEV_W;
            ecmd[1] = 6'h01; etx[1] = a;
            ecmd[2] = 6'h09; etx[2] = d;
            len = 3;
        end else begin
            ecmd[0] = 6'h03; etx[0] = DEV_W;
            ecmd[1] = 6'h01; etx[1] = a;
            ecmd[2] = 6'h03; etx[2] = DEV_R;
            ecmd[3] = 6'h2C; etx[3] = 8'h00;
            len = 4;
        end
        fault = (nack_step >= 0) && (nack_step < len) && ecmd[nack_step][0];
        n = len;
        if (fault) begin
            n = nack_step + 1;
            if (!ecmd[nack_step][3]) begin
                ecmd[n] = 6'h08; etx[n] = 8'h00;
                n++;
            end
        end
        exp_rd = (rd_op && !fault) ? rx : m_rddata;

        wrreg_req = wr | both;
        rdreg_req = !wr | both;
        addr = a;
        wrdata = d;
        @(negedge Clk);
        wrreg_req = 1'b0;
        rdreg_req = 1'b0;
        addr = 8'($urandom);
        wrdata = 8'($urandom);
        chk("busy_accept", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);
        Trans_Done = 1'($urandom);

        for (int i = 0; i < n; i++) begin
            wait_go(wt);
            chk("go_latency", 32'(wt), 32'd1);
            chk("cmd", 32'(Cmd), 32'(ecmd[i]));
            chk("tx", 32'(Tx_DATA), 32'(etx[i]));
            chk("done_early", 32'(RW_Done), 32'd0);
            @(negedge Clk);
            chk("go_pulse", 32'(Go), 32'd0);
            repeat ($urandom_range(3, 0)) begin
                wrreg_req = 1'($urandom);
                rdreg_req = 1'($urandom);
                @(negedge Clk);
            end
            wrreg_req = 1'b0;
            rdreg_req = 1'b0;
            Trans_Done = 1'b1;
            if (fault && i == nack_step) ack_o = 1'b1;
            else if (!ecmd[i][0]) ack_o = 1'($urandom);
            else ack_o = 1'b0;
            Rx_DATA = (i == n - 1) ? rx : 8'($urandom);
            @(negedge Clk);
            Trans_Done = 1'b0;
            ack_o = 1'b0;
            Rx_DATA = 8'($urandom);
        end

        chk("rw_done", 32'(RW_Done), 32'd1);
        chk("err", 32'(err), 32'(fault));
        chk("rddata", 32'(rddata), 32'(exp_rd));
        chk("busy_done", 32'(busy), 32'd1);
        chk("no_extra_go", 32'(Go), 32'd0);
        m_rddata = exp_rd;
        rdreg_req = 1'b1;
        @(negedge Clk);
        rdreg_req = 1'b0;
        chk("done_pulse", 32'(RW_Done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rddata_hold", 32'(rddata), 32'(m_rddata));
    endtask

    initial begin
        int wt;
        Rst_n = 1'b0;
        wrreg_req = 1'b0; rdreg_req = 1'b0;
        addr = '0; wrdata = '0; Rx_DATA = '0;
        Trans_Done = 1'b0; ack_o = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_rddata", 32'(rddata), 32'd0);
        chk("rst_done", 32'(RW_Done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd", 32'(Cmd), 32'd0);
        chk("rst_go", 32'(Go), 32'd0);
        chk("rst_tx", 32'(Tx_DATA), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        run_req(1'b1, 1'b0, 8'hB1, 8'hDA, -1, 8'h00);
        run_req(1'b0, 1'b0, 8'hB1, 8'h00, -1, 8'hDA);
        run_req(1'b1, 1'b0, 8'hB1, 8'hDA, 0, 8'h00);
        run_req(1'b0, 1'b0, 8'hB1, 8'h00, 2, 8'h55);
        run_req(1'b1, 1'b1, 8'h3C, 8'h7E, -1, 8'h11);
        run_req(1'b1, 1'b0, 8'h12, 8'h34, 2, 8'h00);
        run_req(1'b0, 1'b0, 8'h40, 8'h00, 3, 8'hC3);

        for (int k = 0; k < 30; k++) begin
            int ns;
            ns = ($urandom_range(9, 0) < 6) ? -1 : int'($urandom_range(3, 0));
            run_req(1'($urandom), 1'($urandom_range(7, 0) == 0), 8'($urandom), 8'($urandom),
                    ns, 8'($urandom));
        end

        // Reset while waiting on step 1 of a read
        rdreg_req = 1'b1;
        addr = 8'hB1;
        @(negedge Clk);
        rdreg_req = 1'b0;
        wait_go(wt);
        @(negedge Clk);
        Trans_Done = 1'b1;
        @(negedge Clk);
        Trans_Done = 1'b0;
        wait_go(wt);
        chk("pre_rst_cmd", 32'(Cmd), 32'h01);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_rddata", 32'(rddata), 32'd0);
        chk("mid_rst_done", 32'(RW_Done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd", 32'(Cmd), 32'd0);
        chk("mid_rst_go", 32'(Go), 32'd0);
        chk("mid_rst_tx", 32'(Tx_DATA), 32'd0);
        m_rddata = 8'h00;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        run_req(1'b1, 1'b0, 8'hB1, 8'hDA, -1, 8'h00);
        run_req(1'b0, 1'b0, 8'hB1, 8'h00, -1, 8'h9A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
